ivector_driver: RTL and testbench
=================================

Name: ivector_driver

Overview:
- Initiator and checker for the IVector echo path.
- Drives the IVectorRequest client side (say) with a deterministic stream of ValuePair transactions, and acts as the IndIF server (heard).
- Checks every echoed ValuePair against an in-order scoreboard, then reports done and an error count.
- Sits opposite the IVector echo block in self-checking test top levels and bring-up images.

Parameters:
- COUNT, 16: transactions issued per run (1..65535).
- DEPTH, 4: scoreboard entries, i.e. max outstanding transactions; power of 2, >=2.
- SEED, 32'h00000001: base value for a-field generation.
- TIMEOUT, 1024: watchdog limit in cycles; used only with IVECTOR_DRIVER_TIMEOUT_EN.

Ports:
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high
- start__ENA  in  1  begin a run
- start__RDY  out  1  ready for start (state IDLE or DONE)
- request$say__ENA  out  1  issue transaction
- request$say$v  out  96  ValuePair {c[95:64], b[63:32], a[31:0]}
- request$say__RDY  in  1  echo block can accept
- ind$heard__ENA  in  1  echoed transaction valid
- ind$heard$v  in  96  echoed ValuePair, same packing
- ind$heard__RDY  out  1  scoreboard has an entry to compare
- done  out  1  run complete, held until next start
- errors  out  16  mismatch count, saturates at 16'hFFFF
- timeout  out  1  watchdog fired; constant 0 when feature absent

Behaviour:
- States: IDLE, RUN, DRAIN, DONE. On RST: state=IDLE, issued=0, received=0, errors=0, scoreboard empty, done=0, timeout=0.
- While RST is high, all ENA/RDY outputs are 0. Reset mid-run abandons all outstanding entries.
- IDLE/DONE -> RUN on start__ENA && start__RDY. Entry to RUN clears issued, received, errors, scoreboard, done and timeout.
- Generation: transaction i (0-based): a = SEED + i; b = a ^ 32'hA5A5A5A5; c = a + b. All arithmetic is 32-bit modulo 2^32.
- request$say$v is driven from registers holding transaction i = issued.
- request$say__ENA = (state==RUN) && (issued<COUNT) && (sb_count<DEPTH) && request$say__RDY. This is combinational on RDY, per the ENA-implies-RDY rule.
- On say fire: push {c,b,a} into the scoreboard, issued+=1, and advance the generator registers next cycle. Issue rate is one transaction per cycle maximum.
- RUN -> DRAIN in the cycle after issued reaches COUNT.
- ind$heard__RDY = (state==RUN || state==DRAIN) && (sb_count!=0).
- On heard fire: compare ind$heard$v with the scoreboard head. On mismatch, errors+=1 (saturating). Then pop and received+=1.
- Push and pop in the same cycle leave sb_count unchanged. Push is blocked whenever sb_count==DEPTH at the start of the cycle, even if a pop occurs that cycle.
- Scoreboard is a circular buffer with read/write pointers of log2(DEPTH) bits that wrap naturally. sb_count is log2(DEPTH)+1 bits.
- DRAIN -> DONE when received==COUNT (sb_count==0); done=1 from the next cycle.
- start__ENA in RUN/DRAIN is not accepted (start__RDY=0).
- heard__ENA while heard__RDY=0 is a protocol violation and is ignored: no pop, no count.

Optional Feature:
- Macro IVECTOR_DRIVER_TIMEOUT_EN.
- With the macro: a cycle counter runs in RUN/DRAIN and is cleared on any say or heard fire. When it reaches TIMEOUT, go to DONE with timeout=1 and done=1. Outstanding entries are discarded (sb_count=0). errors is unchanged.
- Without the macro: no counter is instantiated, the timeout output is constant 0, and a hung echo path holds RUN/DRAIN indefinitely.

Test Plan:
- Loopback echo with 1-cycle registered turnaround, COUNT=16, SEED=1, start pulse -> first say carries a=1, b=A5A5A5A4, c=A5A5A5A5; done=1 with errors=0, issued=received=16.
- Echo corrupts bit 0 of field c on transactions 3 and 7 -> errors=2 at done; the remaining 14 compare clean.
- request$say__RDY held 0 for 20 cycles mid-run, and ind$heard__RDY stalled by a responder that withholds heard until sb_count==DEPTH=4 -> say__ENA deasserts at 4 outstanding; no lost or duplicated compares; errors=0.
- SEED=32'hFFFFFFFE, COUNT=4 -> a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001 (wrap); c computed modulo 2^32; errors=0.
- RST asserted with 2 outstanding entries, then a new start -> all outputs at reset values the cycle after RST; the fresh run completes with errors=0.
- With IVECTOR_DRIVER_TIMEOUT_EN, TIMEOUT=64, responder never asserts heard -> timeout=1 and done=1 exactly 64 cycles after the last say fire; errors=0.

Source files
------------

// File: rtl/ivector_driver.sv
// IVector echo-path initiator/checker: issues a deterministic ValuePair stream on say and
// scoreboards the echoes on heard. Optional watchdog under IVECTOR_DRIVER_TIMEOUT_EN.
module ivector_driver #(
  parameter int unsigned COUNT   = 16,
  parameter int unsigned DEPTH   = 4,
  parameter logic [31:0] SEED    = 32'h0000_0001,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start__ENA,
  output logic        start__RDY,
  output logic        request_say__ENA,
  output logic [95:0] request_say_v,
  input  logic        request_say__RDY,
  input  logic        ind_heard__ENA,
  input  logic [95:0] ind_heard_v,
  output logic        ind_heard__RDY,
  output logic        done,
  output logic [15:0] errors,
  output logic        timeout
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [31:0] BMask = 32'hA5A5_A5A5;
  localparam logic [31:0] SeedB = SEED ^ BMask;
  localparam logic [31:0] SeedC = SEED + SeedB;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e      r_state, w_state_next;
  logic [15:0] r_issued, r_received, r_errors;
  logic [PtrW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PtrW:0]   r_sb_count;
  logic [95:0] r_sb [DEPTH];
  logic [31:0] r_a, r_b, r_c;
  logic [31:0] w_a_next, w_b_next, w_c_next;
  logic        w_active, w_start_fire, w_say_fire, w_heard_fire, w_mismatch, w_timeout_fire;

  assign w_active     = (r_state == StRun) || (r_state == StDrain);
  assign w_start_fire = start__ENA && start__RDY;
  assign w_say_fire   = request_say__ENA;
  assign w_heard_fire = ind_heard__ENA && ind_heard__RDY;
  assign w_mismatch   = ind_heard_v != r_sb[r_rd_ptr];

  assign w_a_next = r_a + 32'd1;
  assign w_b_next = w_a_next ^ BMask;
  assign w_c_next = w_a_next + w_b_next;

  assign request_say_v = {r_c, r_b, r_a};
  assign errors        = r_errors;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StDone: if (w_start_fire) w_state_next = StRun;
      StRun: begin
        if (w_timeout_fire)                w_state_next = StDone;
        else if (32'(r_issued) == COUNT)   w_state_next = StDrain;
      end
      StDrain: begin
        if (w_timeout_fire)                w_state_next = StDone;
        else if (32'(r_received) == COUNT) w_state_next = StDone;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Handshake outputs are forced low while RST is held, regardless of state.
  always_comb begin
    start__RDY       = 1'b0;
    request_say__ENA = 1'b0;
    ind_heard__RDY   = 1'b0;
    done             = 1'b0;
    if (!RST) begin
      unique case (r_state)
        StIdle: start__RDY = 1'b1;
        StRun: begin
          request_say__ENA = (32'(r_issued) < COUNT) && (32'(r_sb_count) < DEPTH) &&
                             request_say__RDY;
          ind_heard__RDY   = r_sb_count != '0;
        end
        StDrain: ind_heard__RDY = r_sb_count != '0;
        StDone: begin
          start__RDY = 1'b1;
          done       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_issued   <= '0;
      r_received <= '0;
      r_errors   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_sb_count <= '0;
      r_a        <= SEED;
      r_b        <= SeedB;
      r_c        <= SeedC;
    end else if (w_start_fire) begin
      r_issued   <= '0;
      r_received <= '0;
      r_errors   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_sb_count <= '0;
      r_a        <= SEED;
      r_b        <= SeedB;
      r_c        <= SeedC;
    end else begin
      if (w_say_fire) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_issued <= r_issued + 16'd1;
        r_a      <= w_a_next;
        r_b      <= w_b_next;
        r_c      <= w_c_next;
      end
      if (w_heard_fire) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_received <= r_received + 16'd1;
        if (w_mismatch && (r_errors != 16'hFFFF)) r_errors <= r_errors + 16'd1;
      end
      if (w_say_fire && !w_heard_fire)      r_sb_count <= r_sb_count + 1'b1;
      else if (!w_say_fire && w_heard_fire) r_sb_count <= r_sb_count - 1'b1;
      // Watchdog expiry only happens in a cycle with no fires; drop all outstanding entries.
      if (w_timeout_fire) begin
        r_rd_ptr   <= r_wr_ptr;
        r_sb_count <= '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_say_fire) r_sb[r_wr_ptr] <= request_say_v;
  end

`ifdef IVECTOR_DRIVER_TIMEOUT_EN
  logic [31:0] r_wd;
  logic        r_timeout;

  always_ff @(posedge CLK) begin
    if (RST || w_start_fire) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_say_fire || w_heard_fire) r_wd <= '0;
      else if (w_active)              r_wd <= r_wd + 32'd1;
      if (w_timeout_fire)             r_timeout <= 1'b1;
    end
  end

  // r_wd counts idle cycles since the last fire; expire on the TIMEOUT-th one.
  assign w_timeout_fire = w_active && !w_say_fire && !w_heard_fire && (r_wd == TIMEOUT - 1);
  assign timeout        = r_timeout;
`else
  assign w_timeout_fire = 1'b0;
  assign timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_ivector_driver.sv
// Scoreboard bench for ivector_driver: expected say vectors are queued by the stimulus and
// popped by monitors on every say fire; a bench-side responder echoes (or withholds) heard.
module tb_ivector_driver;

  localparam int unsigned Count   = 16;
  localparam int unsigned Depth   = 4;
  localparam int unsigned Timeout = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst, start_ena, start_rdy, say_ena, say_rdy, heard_ena, heard_rdy;
  logic        done, tmo;
  logic [95:0] say_v, heard_v;
  logic [15:0] errors;

  logic        start2_ena, start2_rdy, say2_ena, heard2_ena, heard2_rdy, done2, tmo2;
  logic [95:0] say2_v, heard2_v;
  logic [15:0] errors2;

  ivector_driver #(.COUNT(Count), .DEPTH(Depth), .SEED(32'h0000_0001), .TIMEOUT(Timeout)) u_dut (
    .CLK(clk), .RST(rst), .start__ENA(start_ena), .start__RDY(start_rdy),
    .request_say__ENA(say_ena), .request_say_v(say_v), .request_say__RDY(say_rdy),
    .ind_heard__ENA(heard_ena), .ind_heard_v(heard_v), .ind_heard__RDY(heard_rdy),
    .done(done), .errors(errors), .timeout(tmo)
  );

  ivector_driver #(.COUNT(4), .DEPTH(Depth), .SEED(32'hFFFF_FFFE), .TIMEOUT(Timeout)) u_dut2 (
    .CLK(clk), .RST(rst), .start__ENA(start2_ena), .start__RDY(start2_rdy),
    .request_say__ENA(say2_ena), .request_say_v(say2_v), .request_say__RDY(1'b1),
    .ind_heard__ENA(heard2_ena), .ind_heard_v(heard2_v), .ind_heard__RDY(heard2_rdy),
    .done(done2), .errors(errors2), .timeout(tmo2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [95:0] exp_q[$], echo_q[$], exp2_q[$], echo2_q[$];
  int  mode = 0;  // 0 loopback, 1 corrupt c[0] on #3/#7, 2 withhold until Depth queued, 3 mute
  logic say_rdy_drv = 1'b1;
  bit  release_f = 1'b0;
  int  say_cnt = 0, heard_cnt = 0, max_out = 0, echo_idx = 0, last_fire_cyc = 0, say2_cnt = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] model(input logic [31:0] seed, input int i);
    logic [31:0] a, b;
    a = seed + 32'(i);
    b = a ^ 32'hA5A5_A5A5;
    return {a + b, b, a};
  endfunction

  // Responder for u_dut: drive at negedge, then record which handshakes the next edge takes.
  always @(negedge clk) begin
    logic present;
    if (echo_q.size() >= Depth || say_cnt == Count) release_f = 1'b1;
    if (echo_q.size() == 0 && say_cnt != Count)     release_f = 1'b0;
    present   = (echo_q.size() > 0) && (mode == 0 || mode == 1 || (mode == 2 && release_f));
    heard_ena = present;
    heard_v   = '0;
    if (present) begin
      heard_v = echo_q[0];
      if (mode == 1 && (echo_idx == 3 || echo_idx == 7)) heard_v = heard_v ^ (96'h1 << 64);
    end
    say_rdy = say_rdy_drv;
    #1;
    if (say_ena && say_rdy) echo_q.push_back(say_v);
    if (heard_ena && heard_rdy) begin
      void'(echo_q.pop_front());
      echo_idx++;
    end
  end

  always @(negedge clk) begin
    int out;
    #2;
    if (!rst) begin
      if (say_ena) begin
        out = say_cnt - heard_cnt;
        check("say_ena_implies_rdy", 96'(say_rdy), 96'(1));
        check("say_outstanding_lt_depth", 96'(out < Depth), 96'(1));
        if (exp_q.size() == 0) check("say_expected", 96'(0), 96'(1));
        else                   check("say_v", say_v, exp_q.pop_front());
        say_cnt++;
        last_fire_cyc = cyc + 1;
        if (out + 1 > max_out) max_out = out + 1;
      end
      if (heard_ena && heard_rdy) heard_cnt++;
    end
  end

  // Plain 1-cycle loopback for u_dut2.
  always @(negedge clk) begin
    heard2_ena = echo2_q.size() > 0;
    heard2_v   = heard2_ena ? echo2_q[0] : '0;
    #1;
    if (say2_ena) echo2_q.push_back(say2_v);
    if (heard2_ena && heard2_rdy) void'(echo2_q.pop_front());
  end

  always @(negedge clk) begin
    #2;
    if (!rst && say2_ena) begin
      if (exp2_q.size() == 0) check("say2_expected", 96'(0), 96'(1));
      else                    check("say2_v", say2_v, exp2_q.pop_front());
      say2_cnt++;
    end
  end

  task automatic run_start();
    say_cnt = 0; heard_cnt = 0; max_out = 0; echo_idx = 0;
    echo_q.delete();
    @(negedge clk); start_ena = 1'b1;
    @(negedge clk); start_ena = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk); #3;
      if (done) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: done=%0b after %0d cycles, expected 1", name, done, limit);
    end
  endtask

  task automatic wait_say(input int target, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk); #3;
      if (say_cnt >= target) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_say: say count %0d, expected %0d", say_cnt, target);
    end
  endtask

  task automatic check_end(input string tag, input int exp_err);
    check({tag, "_done"}, 96'(done), 96'(1));
    check({tag, "_errors"}, 96'(errors), 96'(exp_err));
    check({tag, "_issued"}, 96'(say_cnt), 96'(Count));
    check({tag, "_received"}, 96'(heard_cnt), 96'(Count));
    check({tag, "_start_rdy"}, 96'(start_rdy), 96'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish, expected completion");
    $fatal(1, "bench hung");
  end

  initial begin
    int snap;
    rst = 1'b1; start_ena = 1'b0; start2_ena = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    check("rst_start_rdy", 96'(start_rdy), 96'(0));
    check("rst_say_ena", 96'(say_ena), 96'(0));
    check("rst_heard_rdy", 96'(heard_rdy), 96'(0));
    check("rst_done", 96'(done), 96'(0));
    check("rst_errors", 96'(errors), 96'(0));
    check("rst_timeout", 96'(tmo), 96'(0));
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #3;
    check("idle_start_rdy", 96'(start_rdy), 96'(1));

    // Clean loopback, first vector hand-computed.
    mode = 0;
    exp_q.push_back({32'hA5A5_A5A5, 32'hA5A5_A5A4, 32'h0000_0001});
    for (int i = 1; i < Count; i++) exp_q.push_back(model(32'h1, i));
    run_start();
    wait_done("loopback_done", 200);
    check_end("loopback", 0);
    check("loopback_timeout", 96'(tmo), 96'(0));

    // Corrupt c[0] on echoes 3 and 7.
    mode = 1;
    for (int i = 0; i < Count; i++) exp_q.push_back(model(32'h1, i));
    run_start();
    wait_done("corrupt_done", 200);
    check_end("corrupt", 2);

    // Back-pressure on say plus a responder that withholds until the scoreboard is full.
    mode = 2;
    for (int i = 0; i < Count; i++) exp_q.push_back(model(32'h1, i));
    run_start();
    wait_say(6, 200);
    say_rdy_drv = 1'b0;
    snap = say_cnt;
    repeat (20) @(negedge clk);
    #3;
    check("stall_no_say", 96'(say_cnt), 96'(snap));
    say_rdy_drv = 1'b1;
    wait_done("stall_done", 400);
    check_end("stall", 0);
    check("stall_max_outstanding", 96'(max_out), 96'(Depth));

    // Second instance: a-field wraps through zero.
    exp2_q.push_back({32'h5A5A_5A59, 32'h5A5A_5A5B, 32'hFFFF_FFFE});
    exp2_q.push_back({32'h5A5A_5A59, 32'h5A5A_5A5A, 32'hFFFF_FFFF});
    exp2_q.push_back({32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000});
    exp2_q.push_back({32'hA5A5_A5A5, 32'hA5A5_A5A4, 32'h0000_0001});
    say2_cnt = 0;
    @(negedge clk); start2_ena = 1'b1;
    @(negedge clk); start2_ena = 1'b0;
    for (int i = 0; i < 100 && !done2; i++) @(negedge clk);
    #3;
    check("wrap_done", 96'(done2), 96'(1));
    check("wrap_errors", 96'(errors2), 96'(0));
    check("wrap_issued", 96'(say2_cnt), 96'(4));
    check("wrap_exp_drained", 96'(exp2_q.size()), 96'(0));

    // Reset with two entries outstanding, then a fresh run.
    mode = 3;
    for (int i = 0; i < Count; i++) exp_q.push_back(model(32'h1, i));
    run_start();
    wait_say(2, 50);
    say_rdy_drv = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete(); echo_q.delete();
    #3;
    check("midrst_say_ena", 96'(say_ena), 96'(0));
    check("midrst_heard_rdy", 96'(heard_rdy), 96'(0));
    check("midrst_start_rdy", 96'(start_rdy), 96'(0));
    @(negedge clk); rst = 1'b0;
    #3;
    check("postrst_done", 96'(done), 96'(0));
    check("postrst_errors", 96'(errors), 96'(0));
    check("postrst_timeout", 96'(tmo), 96'(0));
    check("postrst_start_rdy", 96'(start_rdy), 96'(1));
    check("postrst_heard_rdy", 96'(heard_rdy), 96'(0));
    mode = 0; say_rdy_drv = 1'b1;
    for (int i = 0; i < Count; i++) exp_q.push_back(model(32'h1, i));
    run_start();
    wait_done("rerun_done", 200);
    check_end("rerun", 0);

`ifdef IVECTOR_DRIVER_TIMEOUT_EN
    // Mute responder: watchdog fires Timeout cycles after the last say.
    mode = 3;
    for (int i = 0; i < Count; i++) exp_q.push_back(model(32'h1, i));
    run_start();
    wait_done("wd_done", 300);
    check("wd_timeout", 96'(tmo), 96'(1));
    check("wd_errors", 96'(errors), 96'(0));
    check("wd_latency", 96'(cyc - last_fire_cyc), 96'(Timeout));
    check("wd_issued", 96'(say_cnt), 96'(Depth));
    check("wd_heard_rdy", 96'(heard_rdy), 96'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
